// File: rtl/hpu_axil_pkg.sv
// Shared types and constants for the accelerator's AXI-Lite command master.
// Holds the FSM state encoding, the register map offsets and the AXI response codes.
package hpu_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    localparam logic [11:0] REG_CTRL    = 12'h000;
    localparam logic [11:0] REG_CONTROL = 12'h010;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: turns one local command at a time into a single AXI-Lite write or read.
// A watchdog bounds every handshake wait and aborts with an error response when it expires.
module axil_cmd_master
    import hpu_axil_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESETN,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,

    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,

    output logic [31:0]       M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,

    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,

    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,

    output logic [31:0]       M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,

    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    state_t            state;
    state_t            state_next;
    logic              aw_done;
    logic              w_done;
    logic [WD_W-1:0]   wd_count;
    logic              wd_expired;
    logic              accept;
    logic              aw_fire;
    logic              w_fire;
    logic              b_fire;
    logic              ar_fire;
    logic              r_fire;
    logic              rsp_fire;
    logic              rsp_err_next;
    logic [31:0]       rsp_rdata_next;
    logic              unused_bits;

    // Byte address is word-aligned and zero-extended onto the 32-bit bus.
    function automatic logic [31:0] word_addr(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        w[1:0] = 2'b00;
        return w;
    endfunction

    assign accept     = (state == IDLE) && cmd_valid && cmd_ready;
    assign aw_fire    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_fire     = M_AXI_WVALID  && M_AXI_WREADY;
    assign b_fire     = M_AXI_BVALID  && M_AXI_BREADY;
    assign ar_fire    = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_fire     = M_AXI_RVALID  && M_AXI_RREADY;
    assign wd_expired = (state != IDLE) && (wd_count == WD_W'(TIMEOUT - 1));

    assign M_AXI_WSTRB = 4'hf;
    assign unused_bits = ^{cmd_addr[1:0], M_AXI_BRESP[0], M_AXI_RRESP[0]};

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A handshake is always checked before the watchdog so a same-cycle response wins.
    always_comb begin
        state_next     = state;
        rsp_fire       = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = 32'h0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = cmd_write ? WADDR : RADDR;
                end
            end
            WADDR: begin
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    state_next = WRESP;
                end else if (wd_expired) begin
                    state_next   = IDLE;
                    rsp_fire     = 1'b1;
                    rsp_err_next = 1'b1;
                end
            end
            WRESP: begin
                if (b_fire) begin
                    state_next   = IDLE;
                    rsp_fire     = 1'b1;
                    rsp_err_next = M_AXI_BRESP[1];
                end else if (wd_expired) begin
                    state_next   = IDLE;
                    rsp_fire     = 1'b1;
                    rsp_err_next = 1'b1;
                end
            end
            RADDR: begin
                if (ar_fire) begin
                    state_next = RDATA;
                end else if (wd_expired) begin
                    state_next   = IDLE;
                    rsp_fire     = 1'b1;
                    rsp_err_next = 1'b1;
                end
            end
            RDATA: begin
                if (r_fire) begin
                    state_next     = IDLE;
                    rsp_fire       = 1'b1;
                    rsp_err_next   = M_AXI_RRESP[1];
                    rsp_rdata_next = M_AXI_RDATA;
                end else if (wd_expired) begin
                    state_next   = IDLE;
                    rsp_fire     = 1'b1;
                    rsp_err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Valids/readies decode from the state register, so reset or abort drops them at once.
    always_comb begin
        M_AXI_AWVALID = (state == WADDR) && !aw_done;
        M_AXI_WVALID  = (state == WADDR) && !w_done;
        M_AXI_BREADY  = (state == WRESP);
        M_AXI_ARVALID = (state == RADDR);
        M_AXI_RREADY  = (state == RDATA);
    end

    // cmd_ready stays low through the rsp_valid cycle and reopens one cycle later.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 32'h0;
            M_AXI_AWADDR <= 32'h0;
            M_AXI_WDATA  <= 32'h0;
            M_AXI_ARADDR <= 32'h0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            wd_count     <= '0;
        end else begin
            cmd_ready <= (state_next == IDLE) && !rsp_fire;
            rsp_valid <= rsp_fire;

            if (rsp_fire) begin
                rsp_err   <= rsp_err_next;
                rsp_rdata <= rsp_rdata_next;
            end

            if (accept) begin
                if (cmd_write) begin
                    M_AXI_AWADDR <= word_addr(cmd_addr);
                    M_AXI_WDATA  <= cmd_wdata;
                end else begin
                    M_AXI_ARADDR <= word_addr(cmd_addr);
                end
            end

            if (accept) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_done <= 1'b1;
                end
                if (w_fire) begin
                    w_done <= 1'b1;
                end
            end

            if (state_next != state) begin
                wd_count <= '0;
            end else if (state != IDLE) begin
                wd_count <= wd_count + WD_W'(1);
            end
        end
    end

endmodule
